tc_program_loader8: RTL and testbench

//   Writable 256x8 program memory plus a byte-stream loader FSM. Loads a framed image (LEN, data, checksum)

---
 rtl/tc_program_loader8.sv | 107 ++++++++++
 tb/tb_tc_program_loader8.sv | 224 ++++++++++++++++++++++
 2 files changed

// File: rtl/tc_program_loader8.sv
// rtl/tc_program_loader8.sv - 256x8 program memory with framed byte-stream loader
// Frames are LEN, LEN data bytes (LEN=0 means 256), then a checksum making the byte sum zero.
module tc_program_loader8 #(
  parameter int MEM_BYTES = 256
) (
  input  logic       clk,
  input  logic       rst,
  input  logic       start,
  input  logic [7:0] in_data,
  input  logic       in_valid,
  output logic       in_ready,
  input  logic [7:0] address,
  output logic [7:0] out,
  output logic       cpu_hold,
  output logic       done,
  output logic       error,
  output logic [8:0] count
);

  typedef enum logic [2:0] {
    S_IDLE,
    S_LEN,
    S_DATA,
    S_CSUM,
    S_DONE,
    S_ERR
  } state_t;

  state_t     state;
  logic [7:0] mem [MEM_BYTES];
  logic [7:0] ptr;
  logic [7:0] sum;
  logic [8:0] remaining;
  logic [7:0] csum_total;
  logic       xfer;

  assign in_ready   = (state == S_LEN) || (state == S_DATA) || (state == S_CSUM);
  assign xfer       = in_valid & in_ready;
  assign csum_total = sum + in_data;

  // A stalled or resetting CPU must never see a partially loaded image.
  assign out = (rst || cpu_hold) ? 8'h00 : mem[address];

  always_ff @(posedge clk) begin
    if (!rst && state == S_DATA && xfer) begin
      mem[ptr] <= in_data;
    end
  end

  always_ff @(posedge clk) begin
    if (rst) begin
      state     <= S_IDLE;
      cpu_hold  <= 1'b0;
      done      <= 1'b0;
      error     <= 1'b0;
      count     <= 9'd0;
      ptr       <= 8'd0;
      sum       <= 8'd0;
      remaining <= 9'd0;
    end else begin
      case (state)
        S_IDLE, S_DONE, S_ERR: begin
          if (start) begin
            state    <= S_LEN;
            cpu_hold <= 1'b1;
            done     <= 1'b0;
            error    <= 1'b0;
            count    <= 9'd0;
            ptr      <= 8'd0;
            sum      <= 8'd0;
          end
        end
        S_LEN: begin
          if (xfer) begin
            remaining <= (in_data == 8'd0) ? 9'd256 : {1'b0, in_data};
            state     <= S_DATA;
          end
        end
        S_DATA: begin
          if (xfer) begin
            ptr       <= ptr + 8'd1;
            sum       <= csum_total;
            count     <= count + 9'd1;
            remaining <= remaining - 9'd1;
            if (remaining == 9'd1) begin
              state <= S_CSUM;
            end
          end
        end
        S_CSUM: begin
          if (xfer) begin
            if (csum_total == 8'd0) begin
              state    <= S_DONE;
              done     <= 1'b1;
              cpu_hold <= 1'b0;
            end else begin
              state <= S_ERR;
              error <= 1'b1;
            end
          end
        end
        default: state <= S_IDLE;
      endcase
    end
  end

endmodule

// File: tb/tb_tc_program_loader8.sv
// tb/tb_tc_program_loader8.sv - scoreboard bench for tc_program_loader8
module tb_tc_program_loader8;

  logic       clk = 1'b0;
  logic       rst = 1'b1;
  logic       start = 1'b0;
  logic [7:0] in_data = 8'h00;
  logic       in_valid = 1'b0;
  logic       in_ready;
  logic [7:0] address = 8'h00;
  logic [7:0] out;
  logic       cpu_hold;
  logic       done;
  logic       error;
  logic [8:0] count;

  tc_program_loader8 #(.MEM_BYTES(256)) dut (
    .clk(clk), .rst(rst), .start(start), .in_data(in_data), .in_valid(in_valid),
    .in_ready(in_ready), .address(address), .out(out), .cpu_hold(cpu_hold),
    .done(done), .error(error), .count(count)
  );

  always #5 clk = ~clk;

  typedef struct packed {
    logic       done;
    logic       error;
    logic [8:0] count;
    logic       hold;
  } exp_t;

  exp_t       sb[$];
  logic [7:0] ref_mem [256];
  logic       ref_known [256];
  logic [7:0] fdata[$];
  int         checks = 0;
  int         errors = 0;
  logic       mon_busy = 1'b0;

  task automatic check(input string name, input logic [31:0] act, input logic [31:0] req);
    checks++;
    if (act !== req) begin
      errors++;
      $display("FAIL %s actual=%0h required=%0h", name, act, req);
    end
  endtask

  task automatic pulse_start();
    start = 1'b1;
    @(posedge clk); #1;
    start = 1'b0;
  endtask

  task automatic send_byte(input logic [7:0] b, input int maxgap);
    int   gap;
    logic ok;
    gap = (maxgap > 0) ? int'($urandom_range(0, maxgap)) : 0;
    ok  = 1'b0;
    in_valid = 1'b0;
    repeat (gap) begin @(posedge clk); #1; end
    in_valid = 1'b1;
    in_data  = b;
    for (int n = 0; n < 1000 && !ok; n++) begin
      @(negedge clk);
      if (in_ready) begin
        @(posedge clk); #1;
        ok = 1'b1;
      end
    end
    in_valid = 1'b0;
    if (!ok) check("send_timeout", 32'(ok), 32'd1);
  endtask

  task automatic wait_drain();
    int n;
    n = 0;
    while ((sb.size() != 0 || mon_busy) && n < 3000) begin
      @(posedge clk); #1;
      n++;
    end
    check("drain_timeout", 32'(sb.size() == 0 && !mon_busy), 32'd1);
  endtask

  // Reference: bytes fill memory from 0; the frame is good iff data sum + checksum is 0 mod 256.
  task automatic run_frame(input int maxgap, input int csum_delta, input logic poke_start);
    int         len;
    int         total;
    logic [7:0] csum;
    logic       good;
    exp_t       e;
    len   = fdata.size();
    total = 0;
    for (int i = 0; i < len; i++) begin
      ref_mem[i % 256]   = fdata[i];
      ref_known[i % 256] = 1'b1;
      total += int'(fdata[i]);
    end
    csum = 8'((256 - (total % 256) + csum_delta) % 256);
    good = (((total + int'(csum)) % 256) == 0);
    e.done = good; e.error = !good; e.count = 9'(len); e.hold = !good;
    pulse_start();
    send_byte(8'(len % 256), maxgap);
    for (int i = 0; i < len; i++) begin
      if (poke_start && i == 2) pulse_start();
      send_byte(fdata[i], maxgap);
    end
    sb.push_back(e);
    send_byte(csum, maxgap);
    wait_drain();
  endtask

  task automatic rand_frame(input int len);
    fdata.delete();
    for (int i = 0; i < len; i++) fdata.push_back(8'($urandom_range(0, 255)));
  endtask

  // Monitor: hold and blanked read port while loading; scoreboard pop on each frame end.
  initial begin
    logic prev;
    exp_t e;
    prev = 1'b0;
    forever begin
      @(negedge clk);
      if (in_ready && !rst) begin
        check("hold_while_loading", 32'(cpu_hold), 32'd1);
        check("out_blank_loading", 32'(out), 32'd0);
      end
      if (prev && !in_ready) begin
        mon_busy = 1'b1;
        check("sb_nonempty", 32'(sb.size() != 0), 32'd1);
        if (sb.size() != 0) begin
          e = sb.pop_front();
          check("done", 32'(done), 32'(e.done));
          check("error", 32'(error), 32'(e.error));
          check("count", 32'(count), 32'(e.count));
          check("cpu_hold", 32'(cpu_hold), 32'(e.hold));
          for (int a = 0; a < 256; a++) begin
            address = 8'(a);
            #1;
            if (e.hold) check("out_blank_err", 32'(out), 32'd0);
            else if (ref_known[a]) check("mem_read", 32'(out), 32'(ref_mem[a]));
          end
        end
        mon_busy = 1'b0;
      end
      prev = in_ready;
    end
  end

  initial begin
    exp_t e;
    for (int i = 0; i < 256; i++) ref_known[i] = 1'b0;
    repeat (3) @(posedge clk);
    #1;
    check("rst_out_blank", 32'(out), 32'd0);
    rst = 1'b0;
    @(negedge clk);
    check("rst_in_ready", 32'(in_ready), 32'd0);
    check("rst_cpu_hold", 32'(cpu_hold), 32'd0);
    check("rst_done", 32'(done), 32'd0);
    check("rst_error", 32'(error), 32'd0);
    check("rst_count", 32'(count), 32'd0);
    @(posedge clk); #1;

    fdata = '{8'h11, 8'h22, 8'h33};
    run_frame(0, 0, 1'b0);
    run_frame(0, 1, 1'b0);

    fdata.delete();
    for (int i = 0; i < 256; i++) fdata.push_back(8'(i));
    run_frame(0, 0, 1'b0);

    rand_frame(5);
    run_frame(0, 0, 1'b0);
    run_frame(4, 0, 1'b0);

    // Reset after two of four data bytes.
    rand_frame(2);
    pulse_start();
    send_byte(8'd4, 0);
    for (int i = 0; i < 2; i++) begin
      ref_mem[i] = fdata[i];
      ref_known[i] = 1'b1;
      send_byte(fdata[i], 0);
    end
    e.done = 1'b0; e.error = 1'b0; e.count = 9'd0; e.hold = 1'b0;
    sb.push_back(e);
    rst = 1'b1;
    @(posedge clk); #1;
    rst = 1'b0;
    wait_drain();
    rand_frame(3);
    run_frame(0, 0, 1'b0);

    rand_frame(4);
    run_frame(1, 0, 1'b1);
    in_data  = ~ref_mem[4];
    in_valid = 1'b1;
    repeat (5) begin
      @(negedge clk);
      check("done_in_ready", 32'(in_ready), 32'd0);
      check("done_count", 32'(count), 32'd4);
    end
    @(posedge clk); #1;
    in_valid = 1'b0;
    rand_frame(2);
    run_frame(0, 0, 1'b0);

    for (int k = 0; k < 6; k++) begin
      rand_frame(int'($urandom_range(1, 40)));
      run_frame(int'($urandom_range(0, 2)), ($urandom_range(0, 2) == 0) ? int'($urandom_range(1, 255)) : 0, 1'b0);
    end

    $display("CHECKS %0d ERRORS %0d", checks, errors);
    $finish;
  end

  initial begin
    #2000000;
    $display("FAIL global_timeout actual=running required=finished");
    $fatal(1);
  end

endmodule
